// File: rtl/alu8_share_sched.sv
// Round-robin scheduler sharing one add-with-carry-in datapath among N_REQ requesters.
// Optional build macro ALU_CARRY_OUT_EN adds rsp_cout (carry out of the final pass).
module alu8_share_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   CLK,
  input  logic                   ASYNCRESETN,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
`ifdef ALU_CARRY_OUT_EN
  output logic                   rsp_cout,
`endif
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Requesters hold valid/payload until ready; the response holds valid/id/data until rsp_ready.

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_TWO = 2'b10, OP_NEG = 2'b11} op_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  op_t               op_q;
  logic [WIDTH-1:0]  a_q, b_q, acc;
  logic [ID_W-1:0]   id_q;

  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [N_REQ-1:0]  grant_oh;
  logic [1:0]        sel_op;
  logic [WIDTH-1:0]  sel_a, sel_b;

  logic [WIDTH-1:0]  dp_i0, dp_i1;
  logic              dp_cin;
`ifdef ALU_CARRY_OUT_EN
  logic [WIDTH:0]    dp_sum;
  logic              cout_q;
`else
  logic [WIDTH-1:0]  dp_sum;
`endif

  // Two sweeps: first requesters at or above rr_ptr, then the wrapped-around low ones.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_oh  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_vld && req_valid[i] && (i >= int'(rr_ptr))) begin
        grant_vld   = 1'b1;
        grant_id    = ID_W'(i);
        grant_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_vld && req_valid[i]) begin
        grant_vld   = 1'b1;
        grant_id    = ID_W'(i);
        grant_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  // Shared datapath operand selection: the only adder in the block.
  always_comb begin
    dp_i0  = '0;
    dp_i1  = '0;
    dp_cin = 1'b0;
    if (state == EXEC1) begin
      case (op_q)
        OP_ADD: begin dp_i0 = a_q; dp_i1 = b_q;  dp_cin = 1'b0; end
        OP_SUB: begin dp_i0 = a_q; dp_i1 = ~b_q; dp_cin = 1'b1; end
        OP_TWO: begin dp_i0 = a_q; dp_i1 = b_q;  dp_cin = 1'b0; end
        default: begin dp_i0 = '0; dp_i1 = ~b_q; dp_cin = 1'b1; end
      endcase
    end else if (state == EXEC2) begin
      dp_i0  = acc;
      dp_i1  = ~a_q;
      dp_cin = 1'b1;
    end
  end

`ifdef ALU_CARRY_OUT_EN
  assign dp_sum = {1'b0, dp_i0} + {1'b0, dp_i1} + (WIDTH+1)'(dp_cin);
`else
  assign dp_sum = dp_i0 + dp_i1 + WIDTH'(dp_cin);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = EXEC1;
      EXEC1:   state_nxt = (op_q == OP_TWO) ? EXEC2 : RESP;
      EXEC2:   state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state  <= IDLE;
      rr_ptr <= '0;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= '0;
      acc    <= '0;
`ifdef ALU_CARRY_OUT_EN
      cout_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && grant_vld) begin
        op_q   <= op_t'(sel_op);
        a_q    <= sel_a;
        b_q    <= sel_b;
        id_q   <= grant_id;
        rr_ptr <= (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;
      end
      if (state == EXEC1 || state == EXEC2) begin
        acc <= dp_sum[WIDTH-1:0];
`ifdef ALU_CARRY_OUT_EN
        cout_q <= dp_sum[WIDTH];
`endif
      end
    end
  end

  assign req_ready = (state == IDLE) ? grant_oh : '0;
  assign rsp_valid = (state == RESP);
  assign rsp_data  = acc;
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);
  assign state_dbg = state;
`ifdef ALU_CARRY_OUT_EN
  assign rsp_cout  = cout_q;
`endif

endmodule

// File: tb/tb_alu8_share_sched.sv
// Bench for alu8_share_sched: directed ops, backpressure, fairness, async reset, random traffic.
`timescale 1ns/1ps
module tb_alu8_share_sched;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;
  localparam int EW = 1 + IW + W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready;
  logic [2*N-1:0]  req_op;
  logic [W*N-1:0]  req_a, req_b;
  logic            rsp_valid, rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic [W-1:0]    rsp_data;
  logic            rsp_cout;
  logic            busy;
  logic [1:0]      state_dbg;

  int tests = 0;
  int fails = 0;
  int mptr  = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  alu8_share_sched #(.N_REQ(N), .WIDTH(W)) dut (
    .CLK(clk), .ASYNCRESETN(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef ALU_CARRY_OUT_EN
    .rsp_cout(rsp_cout),
`endif
    .busy(busy), .state_dbg(state_dbg)
  );
`ifndef ALU_CARRY_OUT_EN
  assign rsp_cout = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result and carry of an op straight from the arithmetic definition, modulo 2^W.
  function automatic logic [W:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ai, bi, t, r, m;
    logic c;
    m = 1 << W;
    ai = a; bi = b;
    case (op)
      2'b00:   begin r = ai + bi;          c = (r >= m);   end
      2'b01:   begin r = ai + m - bi;      c = (ai >= bi); end
      2'b10:   begin t = (ai + bi) % m; r = t + m - ai; c = (t >= ai); end
      default: begin r = m - bi;           c = (bi == 0);  end
    endcase
    r = r % m;
    return {c, r[W-1:0]};
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot_of(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]      = 1'b1;
    req_op[2*i +: 2]  = op;
    req_a[W*i +: W]   = a;
    req_b[W*i +: W]   = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    mptr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One op from requester i; optional response hold and a background requester bg.
  task automatic do_single(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold, input int bg);
    logic [W:0] e;
    int n, lat;
    e = model(op, a, b);
    set_req(i, op, a, b);
    #1;
    n = 0;
    while (req_ready !== onehot_of(i) && n < 20) begin @(posedge clk); #1; n++; end
    check("accept_ready", req_ready, onehot_of(i));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    mptr = (i + 1) % N;
    if (bg >= 0) set_req(bg, 2'b00, 8'h11, 8'h22);
    lat = 1;
    check("busy_exec1", busy, 1'b1);
    while (rsp_valid !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      check("busy_wait", busy, 1'b1);
    end
    check("latency", lat, (op == 2'b10) ? 3 : 2);
    check("rsp_data", rsp_data, e[W-1:0]);
    check("rsp_id", rsp_id, i);
`ifdef ALU_CARRY_OUT_EN
    check("rsp_cout", rsp_cout, e[W]);
`endif
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_data", rsp_data, e[W-1:0]);
      check("hold_id", rsp_id, i);
      check("hold_ready", req_ready, '0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("idle_after", busy, 1'b0);
    check("rsp_drop", rsp_valid, 1'b0);
    if (bg >= 0) begin
      check("next_grant", req_ready, onehot_of(bg));
      req_valid[bg] = 1'b0;
    end
  endtask

  // Free-running traffic with scoreboard; fair=1 keeps every requester asserted.
  task automatic run_traffic(input bit fair, input int n_rsp, input int budget);
    logic [N-1:0] acc_set;
    logic [W:0]   m;
    logic [EW-1:0] e;
    int got, cyc, g, gi, gs, ngr;
    acc_set = '0; got = 0; cyc = 0; ngr = 0;
    exp_q.delete();
    while (got < n_rsp && cyc < budget) begin
      for (int i = 0; i < N; i++) begin
        if (acc_set[i] || !req_valid[i]) begin
          if (fair || $urandom_range(0, 2) == 0)
            set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
          else
            req_valid[i] = 1'b0;
        end
      end
      rsp_ready = fair ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      acc_set = req_valid & req_ready;
      if (req_ready != '0) begin
        check("ready_onehot", $onehot(req_ready), 1);
        gi = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) gi = i;
        g = pick(req_valid, mptr);
        check("grant_order", gi, g);
        gs = (g >= 0) ? g : gi;
        m = model(req_op[2*gs +: 2], req_a[W*gs +: W], req_b[W*gs +: W]);
        exp_q.push_back({m[W], IW'(gs), m[W-1:0]});
        mptr = (gs + 1) % N;
        if (fair && ngr < 5) check("fair_order", gi, ngr % N);
        ngr++;
      end
      if (busy) check("ready_busy", req_ready, '0);
      if (rsp_valid && rsp_ready) begin
        check("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("sb_id", rsp_id, e[W+IW-1:W]);
          check("sb_data", rsp_data, e[W-1:0]);
`ifdef ALU_CARRY_OUT_EN
          check("sb_cout", rsp_cout, e[EW-1]);
`endif
          got++;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("traffic_done", got, n_rsp);
    req_valid = '0;
    rsp_ready = 1'b1;
    cyc = 0;
    while (busy && cyc < 10) begin @(posedge clk); #1; cyc++; end
    check("drain_idle", busy, 1'b0);
    rsp_ready = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", req_ready, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, '0);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_cout", rsp_cout, 1'b0);
    check("rst_dbg_idle", state_dbg, 2'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_single(0, 2'b00, 8'h7F, 8'h01, 0, -1);
    do_single(1, 2'b00, 8'hFF, 8'h02, 0, -1);
    do_single(2, 2'b01, 8'h05, 8'h07, 0, -1);
    do_single(3, 2'b01, 8'h07, 8'h05, 0, -1);
    do_single(1, 2'b11, 8'h00, 8'h01, 0, -1);
    do_single(2, 2'b10, 8'h30, 8'hF0, 0, -1);
    do_single(0, 2'b00, 8'h12, 8'h34, 5, 3);

    do_reset();
    run_traffic(1'b1, 6, 200);

    // Async reset in the second pass of a TWO op.
    set_req(2, 2'b10, 8'h30, 8'hF0);
    #1;
    n = 0;
    while (req_ready !== 4'b0100 && n < 20) begin @(posedge clk); #1; n++; end
    check("mid_accept", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_ready", req_ready, '0);
    check("mid_rst_data", rsp_data, '0);
    check("mid_rst_id", rsp_id, '0);
    mptr = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("no_stale_rsp", rsp_valid, 1'b0);
    end
    set_req(0, 2'b00, 8'h01, 8'h01);
    set_req(3, 2'b00, 8'h02, 8'h02);
    #1;
    check("post_reset_grant", req_ready, 4'b0001);
    req_valid = '0;
    #1;

    run_traffic(1'b0, 60, 3000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
